// File: rtl/mp_pkg.sv
// Shared definitions for the multi-precision limb adder/subtractor.
// Holds the mode and state encodings and the limb-count and index-width helpers.
// It contains no logic of its own.
package mp_pkg;

  // Operation encodings. 2'b11 is reserved and behaves as an add.
  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_CSUB = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of limbs in an operand.
  function automatic int nlimb_f(input int width, input int limb);
    return width / limb;
  endfunction

  // Width of the limb index. It is at least one bit, so NLIMB=1 still gets a real register.
  function automatic int idx_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Both subtract flavours run the adder with an inverted b and a carry-in of 1.
  function automatic logic is_sub_f(input logic [1:0] m);
    return (m == MODE_SUB) || (m == MODE_CSUB);
  endfunction

endpackage

// File: rtl/mp_limb_add.sv
// One limb of the datapath: {cout, sum} = a + (b ^ {LIMB{inv}}) + cin.
// Purely combinational. This is the single adder that sits on the critical path.
// It has no state and no handshake.
module mp_limb_add #(
  parameter int LIMB = 128
) (
  input  logic [LIMB-1:0] a_i,
  input  logic [LIMB-1:0] b_i,
  input  logic            inv_i,
  input  logic            cin_i,
  output logic [LIMB-1:0] sum_o,
  output logic            cout_o
);

  logic [LIMB-1:0] b_eff;

  // Invert b for subtraction. Combined with cin=1, this forms the two's complement.
  assign b_eff = b_i ^ {LIMB{inv_i}};

  // The adder is one bit wider than a limb, so its top bit is the limb carry.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + (LIMB + 1)'(cin_i);

endmodule

// File: rtl/mp_limb_addsub.sv
// Multi-precision add / sub / conditional-sub. It resolves one LIMB per cycle and keeps a registered carry between limbs.
// Latency is NLIMB+1 cycles from an accepted start to the done pulse. busy is high for NLIMB cycles.
// start is accepted only in IDLE or DONE. A start during RUN is dropped, not queued.
module mp_limb_addsub
  import mp_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int LIMB  = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o
);

  // WIDTH must be a multiple of LIMB. The limb walk below relies on that.
  localparam int NLIMB = nlimb_f(WIDTH, LIMB);
  localparam int KW    = idx_w_f(NLIMB);
  localparam logic [KW-1:0] K_LAST = KW'(NLIMB - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [1:0]       mode_q;
  logic [KW-1:0]    k_q;
  logic             c_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic [LIMB-1:0]  a_limb;
  logic [LIMB-1:0]  b_limb;
  logic [LIMB-1:0]  sum_d;
  logic             c_d;
  logic             sub;

  assign sub = is_sub_f(mode_q);

  // Operand limb mux. k_q never passes NLIMB-1 while RUN uses these values.
  assign a_limb = a_q[int'(k_q) * LIMB +: LIMB];
  assign b_limb = b_q[int'(k_q) * LIMB +: LIMB];

  mp_limb_add #(
    .LIMB (LIMB)
  ) u_add (
    .a_i    (a_limb),
    .b_i    (b_limb),
    .inv_i  (sub),
    .cin_i  (c_q),
    .sum_o  (sum_d),
    .cout_o (c_d)
  );

  // Control FSM and datapath registers. Outputs are registered here, apart from the final result mux.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mode_q  <= MODE_ADD;
      k_q     <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          res_q[int'(k_q) * LIMB +: LIMB] <= sum_d;
          c_q <= c_d;
          k_q <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            carry_q <= c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request. When DONE accepts one, operations run back-to-back.
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            mode_q  <= mode_i;
            k_q     <= '0;
            c_q     <= is_sub_f(mode_i);
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Conditional subtract that borrowed: show the untouched a. The mux is fed from registers only.
  assign result_o    = ((mode_q == MODE_CSUB) && !carry_q) ? a_q : res_q;
  assign carry_out_o = carry_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_mp_limb_addsub.sv
// Directed bench for mp_limb_addsub. It covers the default 512/128 configuration and three alternate shapes.
// Every expected value is a hand-computed constant.
module tb_mp_limb_addsub;
  import mp_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [1:0]   mode_x = 2'b00;
  logic [519:0] a_x = '0;
  logic [519:0] b_x = '0;
  logic [3:0]   st = 4'b0;

  logic         busy0, done0, co0;
  logic [511:0] res0;
  logic         busy1, done1, co1;
  logic [63:0]  res1;
  logic         busy2, done2, co2;
  logic [519:0] res2;
  logic         busy3, done3, co3;
  logic [511:0] res3;

  logic [3:0]   done_v;
  logic [3:0]   co_v;
  logic [519:0] res_v [4];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mp_limb_addsub #(.WIDTH(512), .LIMB(128)) u0 (
    .clk(clk), .resetn(resetn), .start_i(st[0]), .mode_i(mode_x),
    .a_i(a_x[511:0]), .b_i(b_x[511:0]), .busy_o(busy0), .done_o(done0),
    .result_o(res0), .carry_out_o(co0));

  mp_limb_addsub #(.WIDTH(64), .LIMB(8)) u1 (
    .clk(clk), .resetn(resetn), .start_i(st[1]), .mode_i(mode_x),
    .a_i(a_x[63:0]), .b_i(b_x[63:0]), .busy_o(busy1), .done_o(done1),
    .result_o(res1), .carry_out_o(co1));

  mp_limb_addsub #(.WIDTH(520), .LIMB(104)) u2 (
    .clk(clk), .resetn(resetn), .start_i(st[2]), .mode_i(mode_x),
    .a_i(a_x), .b_i(b_x), .busy_o(busy2), .done_o(done2),
    .result_o(res2), .carry_out_o(co2));

  mp_limb_addsub #(.WIDTH(512), .LIMB(512)) u3 (
    .clk(clk), .resetn(resetn), .start_i(st[3]), .mode_i(mode_x),
    .a_i(a_x[511:0]), .b_i(b_x[511:0]), .busy_o(busy3), .done_o(done3),
    .result_o(res3), .carry_out_o(co3));

  assign done_v = {done3, done2, done1, done0};
  assign co_v   = {co3, co2, co1, co0};
  assign res_v[0] = {8'b0, res0};
  assign res_v[1] = {456'b0, res1};
  assign res_v[2] = res2;
  assign res_v[3] = {8'b0, res3};

  task automatic check(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one operation on instance inst, then wait (bounded) for its done pulse.
  // lat counts the cycles from the start cycle to the cycle in which done is high. It is -1 if done never came.
  task automatic run_op(input int inst, input logic [1:0] md,
                        input logic [519:0] av, input logic [519:0] bv,
                        output logic [519:0] res, output logic co, output int lat);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    mode_x = md;
    a_x = av;
    b_x = bv;
    st = 4'b0;
    st[inst] = 1'b1;
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      st = 4'b0;
      lat++;
      if (done_v[inst]) begin
        seen = 1'b1;
        break;
      end
    end
    res = res_v[inst];
    co  = co_v[inst];
    if (!seen) lat = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [519:0] r;
    logic         c;
    int           lat;
    logic [519:0] ones512;
    logic [519:0] m2_512;
    logic [519:0] half512;
    logic [519:0] top520;

    ones512 = '0;
    ones512[511:0] = '1;
    m2_512 = ones512;
    m2_512[0] = 1'b0;
    half512 = '0;
    half512[511] = 1'b1;
    top520 = '0;
    top520[519] = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", res_v[0], 0);
    check("rst_carry", co0, 0);
    check("rst_busy_other", {busy1, busy2, busy3, done1, done2, done3}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Add with a carry that ripples across every limb.
    run_op(0, MODE_ADD, ones512, 520'd1, r, c, lat);
    check("add_ripple_res", r, 0);
    check("add_ripple_co", c, 1);
    check("add_ripple_lat", lat, 5);

    // Subtract with a borrow. The result wraps modulo 2^512.
    run_op(0, MODE_SUB, 520'd5, 520'd7, r, c, lat);
    check("sub_borrow_res", r, m2_512);
    check("sub_borrow_co", c, 0);
    check("sub_borrow_lat", lat, 5);

    // The result holds after done while the inputs wander.
    @(negedge clk);
    a_x = 520'd99;
    b_x = 520'd42;
    mode_x = MODE_ADD;
    @(negedge clk);
    check("hold_res", res_v[0], m2_512);
    check("hold_co", co0, 0);
    check("hold_done_low", done0, 0);

    // Conditional subtract that would borrow: result is a.
    run_op(0, MODE_CSUB, 520'd5, 520'd7, r, c, lat);
    check("csub_borrow_res", r, 5);
    check("csub_borrow_co", c, 0);

    // Conditional subtract with no borrow.
    run_op(0, MODE_CSUB, half512 + 520'd3, half512, r, c, lat);
    check("csub_nb_res", r, 3);
    check("csub_nb_co", c, 1);

    // Conditional subtract with equal operands.
    run_op(0, MODE_CSUB, half512 + 520'd3, half512 + 520'd3, r, c, lat);
    check("csub_eq_res", r, 0);
    check("csub_eq_co", c, 1);

    // Reserved mode behaves as add.
    run_op(0, 2'b11, 520'd10, 520'd20, r, c, lat);
    check("rsvd_add_res", r, 30);
    check("rsvd_add_co", c, 0);

    // Back-to-back: start is held high and the operands change every cycle.
    // Only the values present at E0, E5 and E10 count.
    @(negedge clk);
    st = 4'b0001;
    a_x = 520'd7;
    b_x = 520'd3;
    mode_x = MODE_ADD;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      check($sformatf("b2b_done_c%0d", cyc), done0, 520'((cyc % 5) == 0));
      check($sformatf("b2b_busy_c%0d", cyc), busy0, 520'((cyc % 5) != 0));
      if (cyc == 5) begin
        check("b2b_res_op0", res_v[0], 10);
        check("b2b_co_op0", co0, 0);
      end
      if (cyc == 10) begin
        check("b2b_res_op1", res_v[0], 499);
        check("b2b_co_op1", co0, 1);
      end
      if (cyc == 15) begin
        check("b2b_res_op2", res_v[0], 994);
        check("b2b_co_op2", co0, 1);
        st = 4'b0;
      end else begin
        a_x = 520'(100 * cyc + 7);
        b_x = 520'(cyc + 3);
        mode_x = 2'(cyc % 3);
      end
    end
    repeat (2) @(negedge clk);

    // Reset during the third RUN cycle aborts the operation.
    @(negedge clk);
    st = 4'b0001;
    a_x = ones512;
    b_x = '0;
    mode_x = MODE_ADD;
    @(negedge clk);
    st = 4'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_res", res_v[0], 0);
    check("midrst_co", co0, 0);
    resetn = 1'b1;
    run_op(0, MODE_ADD, 520'd1, 520'd1, r, c, lat);
    check("postrst_res", r, 2);
    check("postrst_lat", lat, 5);

    // 64/8: eight limbs.
    run_op(1, MODE_ADD, 520'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 520'd1, r, c, lat);
    check("w64_add_res", r, 0);
    check("w64_add_co", c, 1);
    check("w64_add_lat", lat, 9);
    run_op(1, MODE_SUB, 520'h0123_4567_89AB_CDEF, 520'd1, r, c, lat);
    check("w64_sub_res", r, 520'h0123_4567_89AB_CDEE);
    check("w64_sub_co", c, 1);
    run_op(1, MODE_SUB, 520'd0, 520'd1, r, c, lat);
    check("w64_sub0_res", r, 520'hFFFF_FFFF_FFFF_FFFF);
    check("w64_sub0_co", c, 0);
    run_op(1, MODE_CSUB, 520'd3, 520'd5, r, c, lat);
    check("w64_csub_res", r, 3);
    check("w64_csub_co", c, 0);

    // 520/104: five limbs, and the width is not a power of two.
    run_op(2, MODE_ADD, top520, top520, r, c, lat);
    check("w520_add_res", r, 0);
    check("w520_add_co", c, 1);
    check("w520_add_lat", lat, 6);
    run_op(2, MODE_CSUB, top520 + 520'd3, top520, r, c, lat);
    check("w520_csub_res", r, 3);
    check("w520_csub_co", c, 1);

    // 512/512: a single limb, so a single RUN cycle.
    run_op(3, MODE_SUB, 520'd5, 520'd7, r, c, lat);
    check("w512x1_sub_res", r, m2_512);
    check("w512x1_sub_co", c, 0);
    check("w512x1_sub_lat", lat, 2);
    run_op(3, MODE_ADD, 520'd1, 520'd2, r, c, lat);
    check("w512x1_add_res", r, 3);
    check("w512x1_add_lat", lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
